// File: rtl/prog_loader_pkg.sv
// Shared types and default widths for the instruction-memory program loader.
package prog_loader_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int HOLD_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_HOLD,
        ST_RUN,
        ST_ERROR
    } state_t;

endpackage

// File: rtl/prog_cksum.sv
// Running modulo-2^DATA_W sum of the words written during a program load.
module prog_cksum #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              add_en,
    input  logic [DATA_W-1:0] add_data,
    output logic [DATA_W-1:0] sum
);

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            sum <= '0;
        end else if (add_en) begin
            sum <= sum + add_data;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a program into the MIPS instruction memory, then releases the core.
// Define PROG_CHECKSUM_EN to verify a trailing checksum word before release.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RST_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_words,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              we_prog,
    output logic [ADDR_W-1:0] addr_prog,
    output logic [DATA_W-1:0] data_prog,
    output logic              prog_mode,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0]   MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);

    state_t            state;
    logic [ADDR_W:0]   count;
    logic [ADDR_W:0]   counter;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ADDR_W:0]   count_clamped;
    logic              load_req;
    logic              xfer;
    logic              last_word;

    assign count_clamped = (num_words > MAX_WORDS) ? MAX_WORDS : num_words;
    assign load_req      = start && (state == ST_IDLE || state == ST_RUN || state == ST_ERROR);
    assign xfer          = in_valid && in_ready;
    assign last_word     = (counter == count - CNT_ONE);

`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] cksum_sum;

    prog_cksum #(.DATA_W(DATA_W)) u_cksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (load_req),
        .add_en   (state == ST_LOAD && xfer),
        .add_data (in_data),
        .sum      (cksum_sum)
    );
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            count     <= '0;
            counter   <= '0;
            hold_cnt  <= '0;
            in_ready  <= 1'b0;
            we_prog   <= 1'b0;
            addr_prog <= '0;
            data_prog <= '0;
            prog_mode <= 1'b0;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
            err       <= 1'b0;
`endif
        end else begin
            // NOTE: default here makes we_prog a single-cycle strobe; a later branch raises it.
            we_prog <= 1'b0;
            if (load_req) begin
                count     <= count_clamped;
                counter   <= '0;
                hold_cnt  <= '0;
                cpu_reset <= 1'b1;
                done      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
                err       <= 1'b0;
`endif
                if (count_clamped == '0) begin
                    state     <= ST_HOLD;
                    prog_mode <= 1'b1;
                    in_ready  <= 1'b0;
                end else begin
                    state     <= ST_LOAD;
                    prog_mode <= 1'b0;
                    in_ready  <= 1'b1;
                end
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (xfer) begin
                            we_prog   <= 1'b1;
                            addr_prog <= counter[ADDR_W-1:0];
                            data_prog <= in_data;
                            counter   <= counter + CNT_ONE;
                            if (last_word) begin
`ifdef PROG_CHECKSUM_EN
                                state     <= ST_CHECK;
`else
                                state     <= ST_HOLD;
                                in_ready  <= 1'b0;
                                prog_mode <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef PROG_CHECKSUM_EN
                    // The word after the program is the expected sum; it is never written.
                    ST_CHECK: begin
                        if (xfer) begin
                            in_ready <= 1'b0;
                            if (in_data == cksum_sum) begin
                                state     <= ST_HOLD;
                                prog_mode <= 1'b1;
                            end else begin
                                state <= ST_ERROR;
                                err   <= 1'b1;
                            end
                        end
                    end
`endif
                    ST_HOLD: begin
                        if (hold_cnt == HOLD_LAST) begin
                            state     <= ST_RUN;
                            cpu_reset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued at transfer time
// and matched against each we_prog strobe. Covers PROG_CHECKSUM_EN when defined.
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   num_words = '0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              we_prog;
    logic [ADDR_W-1:0] addr_prog;
    logic [DATA_W-1:0] data_prog;
    logic              prog_mode;
    logic              cpu_reset;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;

    wr_t               exp_q[$];
    logic [DATA_W-1:0] word_q[$];
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [DATA_W-1:0] bench_sum = '0;
    int                cyc = 0;
    int                wr_cnt = 0;
    int                first_wr_cyc = 0;
    int                last_wr_cyc = 0;
    int                hold_cyc = 0;

    prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RST_CYCLES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .we_prog   (we_prog),
        .addr_prog (addr_prog),
        .data_prog (data_prog),
        .prog_mode (prog_mode),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor and hold-phase counter, sampled on the falling edge.
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (prog_mode && cpu_reset) hold_cyc++;
        if (we_prog) begin
            wr_cnt++;
            if (wr_cnt == 1) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", addr_prog, e.addr);
                check("wr_data", data_prog, e.data);
            end
        end
    end

    task automatic pulse_start(input int n, input bit accepted);
        @(negedge clk);
        start     = 1'b1;
        num_words = (ADDR_W + 1)'(n);
        if (accepted) begin
            exp_addr  = '0;
            wr_cnt    = 0;
            hold_cyc  = 0;
            bench_sum = '0;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer words until `limit` are accepted, then keep offering for `extra` cycles.
    task automatic feed(input int limit, input bit toggle, input int extra);
        int acc = 0;
        int c = 0;
        bit ph = 1'b1;
        while (acc < limit && c < limit * 4 + 20) begin
            @(negedge clk);
            c++;
            in_valid = toggle ? ph : 1'b1;
            ph = ~ph;
            in_data = (word_q.size() > 0) ? word_q[0] : $urandom();
            if (in_valid && in_ready) begin
                exp_q.push_back('{exp_addr, in_data});
                exp_addr++;
                bench_sum += in_data;
                acc++;
                if (word_q.size() > 0) void'(word_q.pop_front());
            end
        end
        if (acc < limit) check("feed_timeout", acc, limit);
        for (int i = 0; i < extra; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'hDEAD_0000 + i;
        end
    endtask

    task automatic end_load();
`ifdef PROG_CHECKSUM_EN
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = bench_sum;
        check("cksum_ready", in_ready, 1);
`endif
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (!done && i < 20) begin
            @(negedge clk);
            i++;
        end
        check(tag, done, 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_we_prog"}, we_prog, 0);
        check({tag, "_addr"}, addr_prog, 0);
        check({tag, "_data"}, data_prog, 0);
        check({tag, "_prog_mode"}, prog_mode, 0);
        check({tag, "_cpu_reset"}, cpu_reset, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // Three-word program with in_valid held high.
        word_q = '{32'h1060_0DDE, 32'hF800_0004, 32'h0600_0005};
        pulse_start(3, 1'b1);
        check("t1_ready", in_ready, 1);
        check("t1_prog_mode", prog_mode, 0);
        feed(3, 1'b0, 0);
        end_load();
        check("t1_ready_low", in_ready, 0);
        wait_done("t1_done");
        check("t1_writes", wr_cnt, 3);
        check("t1_consecutive", last_wr_cyc - first_wr_cyc, 2);
        check("t1_hold_cycles", hold_cyc, 2);
        check("t1_cpu_reset", cpu_reset, 0);
        check("t1_prog_mode_run", prog_mode, 1);
        check("t1_addr_hold", addr_prog, 2);
        check("t1_data_hold", data_prog, 32'h0600_0005);

        // Restart from RUN with in_valid toggling.
        pulse_start(2, 1'b1);
        check("t2_restart_cpu_reset", cpu_reset, 1);
        check("t2_restart_prog_mode", prog_mode, 0);
        check("t2_restart_done", done, 0);
        feed(2, 1'b1, 0);
        end_load();
        wait_done("t2_done");
        check("t2_writes", wr_cnt, 2);

        // Empty program goes straight to the hold phase.
        pulse_start(0, 1'b1);
        check("t3_ready", in_ready, 0);
        wait_done("t3_done");
        check("t3_writes", wr_cnt, 0);
        check("t3_hold_cycles", hold_cyc, 2);

        // Oversized count clamps to the full memory.
        pulse_start(300, 1'b1);
`ifdef PROG_CHECKSUM_EN
        feed(256, 1'b0, 0);
`else
        feed(256, 1'b0, 5);
`endif
        end_load();
        wait_done("t4_done");
        check("t4_writes", wr_cnt, 256);
        check("t4_last_addr", addr_prog, 255);

        // A start during LOAD must not disturb the transfer.
        pulse_start(4, 1'b1);
        feed(2, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        pulse_start(9, 1'b0);
        check("t5_still_loading", in_ready, 1);
        feed(2, 1'b0, 0);
        end_load();
        wait_done("t5_done");
        check("t5_writes", wr_cnt, 4);
        check("t5_last_addr", addr_prog, 3);

        // Reset mid-load, with a transfer presented on the reset edge.
        pulse_start(13, 1'b1);
        feed(5, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hBAD0_BAD0;
        reset    = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        check("midrst_writes", wr_cnt, 5);
        check("midrst_queue", exp_q.size(), 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        pulse_start(13, 1'b1);
        feed(13, 1'b0, 0);
        end_load();
        wait_done("t6_done");
        check("t6_writes", wr_cnt, 13);

`ifdef PROG_CHECKSUM_EN
        // Matching checksum releases the core.
        word_q = '{32'd1, 32'd2, 32'd3};
        pulse_start(3, 1'b1);
        feed(3, 1'b0, 0);
        @(negedge clk);
        in_data = 32'd6;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("ck_ok_done");
        check("ck_ok_writes", wr_cnt, 3);

        // Mismatching checksum traps in ERROR until the next start.
        word_q = '{32'd1, 32'd2, 32'd3};
        pulse_start(3, 1'b1);
        feed(3, 1'b0, 0);
        @(negedge clk);
        in_data = 32'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("ck_bad_err", err, 1);
        check("ck_bad_cpu_reset", cpu_reset, 1);
        check("ck_bad_prog_mode", prog_mode, 0);
        check("ck_bad_done", done, 0);
        pulse_start(2, 1'b1);
        check("ck_err_cleared", err, 0);
        feed(2, 1'b0, 0);
        end_load();
        wait_done("ck_reload_done");
`endif

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
